// File: rtl/rr_pop_arbiter.sv
// Round-robin arbiter that pops one of NUM_IN fifo ports per cycle into a single-entry valid/ready output stage.
// Optional statistics counters (grant_cnt, stall_cnt) are built when ARB_STATS_EN is defined.
module rr_pop_arbiter #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned WIDTH  = 8,
  localparam int unsigned SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SRC_W-1:0]        out_src,
  input  logic                    out_ready
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]             grant_cnt,
  output logic [31:0]             stall_cnt
`endif
);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] gnt;
  logic [SRC_W-1:0] nxt_ptr;
  logic [WIDTH-1:0] sel_data;
  logic             found;
  logic             load;
  int unsigned      idx;

  assign load = !out_valid || out_ready;

  // First valid port scanning from ptr, wrapping modulo NUM_IN.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int unsigned off = 0; off < NUM_IN; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && in_valid[SRC_W'(idx)]) begin
        found = 1'b1;
        gnt   = SRC_W'(idx);
      end
    end
  end

  // Pop strobe and data mux; pop_ready is never raised on an invalid port or in reset.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (SRC_W'(i) == gnt) begin
        sel_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !rst && load && found;
      end
    end
  end

  assign nxt_ptr = (gnt == SRC_W'(NUM_IN - 1)) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_data <= sel_data;
        out_src  <= gnt;
        ptr      <= nxt_ptr;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Saturating pop and stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (load && found && grant_cnt != 32'hFFFF_FFFF) grant_cnt <= grant_cnt + 32'd1;
      if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rr_pop_arbiter.sv
// Directed and random checks of rr_pop_arbiter against a reference model with a scoreboard queue.
module tb_rr_pop_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;
`ifdef ARB_STATS_EN
  logic [31:0]     grant_cnt;
  logic [31:0]     stall_cnt;
`endif

  always #5 clk = ~clk;

  rr_pop_arbiter #(.NUM_IN(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [SW-1:0] src;
    logic [W-1:0]  data;
  } ent_t;

  ent_t          q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [SW-1:0] m_ptr = '0;
  logic          m_valid = 1'b0;
  int unsigned   m_grant = 0;
  int unsigned   m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check pop strobes, advance model, check output stage.
  task automatic step(input logic r, input logic [N-1:0] v, input logic rdy, input string tag);
    logic           load;
    logic           found;
    logic [SW-1:0]  g;
    logic [N-1:0]   exp_rdy;
    logic [N*W-1:0] d;
    ent_t           e;
    @(negedge clk);
    d         = $urandom;
    rst       = r;
    in_valid  = v;
    out_ready = rdy;
    in_data   = d;
    #1;
    load  = !m_valid || rdy;
    found = 1'b0;
    g     = '0;
    for (int off = 0; off < int'(N); off++) begin
      int k;
      k = (int'(m_ptr) + off) % int'(N);
      if (!found && v[k]) begin
        found = 1'b1;
        g     = SW'(k);
      end
    end
    exp_rdy = '0;
    if (!r && load && found) exp_rdy[g] = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    if (r) begin
      q.delete();
      m_valid = 1'b0;
      m_ptr   = '0;
      m_grant = 0;
      m_stall = 0;
    end else begin
      if (m_valid && !rdy) m_stall++;
      if (load) begin
        if (m_valid) void'(q.pop_front());
        if (found) begin
          e.src  = g;
          e.data = d[int'(g)*W +: W];
          q.push_back(e);
          m_ptr = (g == SW'(N - 1)) ? '0 : g + 1'b1;
          m_grant++;
        end
        m_valid = found;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".out_data"}, 32'(out_data), 32'(q[0].data));
      chk({tag, ".out_src"}, 32'(out_src), 32'(q[0].src));
    end else if (r) begin
      chk({tag, ".rst_data"}, 32'(out_data), 32'd0);
      chk({tag, ".rst_src"}, 32'(out_src), 32'd0);
    end
`ifdef ARB_STATS_EN
    chk({tag, ".grant_cnt"}, grant_cnt, m_grant);
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
`endif
  endtask

  initial begin
    logic [SW-1:0] exp_seq [5];
    exp_seq   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset with all ports valid, then rotation starting at port 0.
    step(1'b1, 4'b1111, 1'b1, "rst0");
    step(1'b1, 4'b1111, 1'b1, "rst1");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 1'b1, "rot");
      chk("rot.seq", 32'(out_src), 32'(exp_seq[i]));
    end

    // Skip and wrap: grant 2 sets ptr=3, then 0101 grants 0 then 2.
    step(1'b0, 4'b0100, 1'b1, "skip_a");
    chk("skip_a.src", 32'(out_src), 32'd2);
    step(1'b0, 4'b0101, 1'b1, "wrap_b");
    chk("wrap_b.src", 32'(out_src), 32'd0);
    step(1'b0, 4'b0101, 1'b1, "wrap_c");
    chk("wrap_c.src", 32'(out_src), 32'd2);

    // Backpressure: output held and stable while inputs churn.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 1'b0, "bp");
      chk("bp.hold_src", 32'(out_src), 32'd2);
    end
    step(1'b0, 4'b0010, 1'b1, "bp_rel");
    chk("bp_rel.src", 32'(out_src), 32'd1);

    // Empty: output drains, ptr stays at 2.
    step(1'b0, 4'b0000, 1'b1, "empty");
    chk("empty.valid", 32'(out_valid), 32'd0);
    step(1'b0, 4'b1111, 1'b1, "after_empty");
    chk("after_empty.src", 32'(out_src), 32'd2);

    // Reset while an entry is held discards it.
    step(1'b0, 4'b1111, 1'b0, "hold");
    step(1'b1, 4'b1111, 1'b1, "mid_rst");
    step(1'b0, 4'b1000, 1'b1, "post_rst");
    chk("post_rst.src", 32'(out_src), 32'd3);

    // Random traffic under random backpressure.
    for (int i = 0; i < 60; i++)
      step(1'b0, N'($urandom), 1'($urandom_range(0, 3) != 0), "rand");

`ifdef ARB_STATS_EN
    step(1'b1, 4'b0000, 1'b1, "st_rst");
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1111, 1'b1, "st_g");
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 1'b0, "st_s");
    chk("stats.grant10", grant_cnt, 32'd10);
    chk("stats.stall3", stall_cnt, 32'd3);
    step(1'b1, 4'b1111, 1'b0, "st_clr");
    chk("stats.grant_clr", grant_cnt, 32'd0);
    chk("stats.stall_clr", stall_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
